// File: rtl/spmv_mem_arbiter.sv
// Shares one PE memory port between NUM_LD tagged load clients and one store client.
// Loads are credit-limited per client so the response FIFOs can never overflow.
module spmv_mem_arbiter #(
  parameter int NUM_LD          = 5,
  parameter int MAX_OUTSTANDING = 16,
  parameter int ADDR_WIDTH      = 48
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_LD-1:0]            ld_req,
  input  logic [NUM_LD*ADDR_WIDTH-1:0] ld_addr,
  output logic [NUM_LD-1:0]            ld_grant,
  output logic [NUM_LD-1:0]            ld_rsp_push,
  output logic [63:0]                  ld_rsp_q,
  input  logic [NUM_LD-1:0]            ld_rsp_pop,
  input  logic                         st_req,
  input  logic [ADDR_WIDTH-1:0]        st_addr,
  input  logic [63:0]                  st_data,
  output logic                         st_grant,
  output logic                         req_mem_ld,
  output logic                         req_mem_st,
  output logic [ADDR_WIDTH-1:0]        req_mem_addr,
  output logic [63:0]                  req_mem_d_or_tag,
  input  logic                         req_mem_stall,
  input  logic                         rsp_mem_push,
  input  logic [2:0]                   rsp_mem_tag,
  input  logic [63:0]                  rsp_mem_q,
  output logic                         rsp_mem_stall,
  output logic                         busy,
  output logic                         tag_err
);

  localparam int NSLOT = NUM_LD + 1;
  localparam int PW    = $clog2(NSLOT);
  localparam int CW    = $clog2(MAX_OUTSTANDING + 1);

  logic [PW-1:0]         r_ptr;
  logic [CW-1:0]         r_cnt [NUM_LD];
  logic                  r_mem_ld;
  logic                  r_mem_st;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [63:0]           r_dtag;
  logic [NUM_LD-1:0]     r_rsp_push;
  logic [63:0]           r_rsp_q;
  logic                  r_tag_err;

  logic [NUM_LD:0]       w_elig;
  logic                  w_gnt_vld;
  logic [PW-1:0]         w_gnt_slot;
  logic [PW-1:0]         w_ptr_nxt;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [63:0]           w_dtag;
  logic [NUM_LD-1:0]     w_pop_ok;
  logic                  w_pop_err;
  logic                  w_rsp_vld;
  logic                  w_rsp_zero;
  logic                  w_rsp_err;
  logic [NUM_LD-1:0]     w_rsp_onehot;
  logic                  w_cnt_nz;

  // Nothing is eligible during reset or memory stall, so no grant can leak out.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_LD; i++) begin
      w_elig[i] = ld_req[i] && (r_cnt[i] < CW'(MAX_OUTSTANDING));
    end
    w_elig[NUM_LD] = st_req;
    if (rst || req_mem_stall) begin
      w_elig = '0;
    end
  end

  always_comb begin
    int idx;
    idx        = 0;
    w_gnt_vld  = 1'b0;
    w_gnt_slot = '0;
    for (int k = 0; k < NSLOT; k++) begin
      idx = (int'(r_ptr) + k) % NSLOT;
      if (!w_gnt_vld && w_elig[idx]) begin
        w_gnt_vld  = 1'b1;
        w_gnt_slot = PW'(idx);
      end
    end
  end

  assign w_ptr_nxt = (w_gnt_slot == PW'(NUM_LD)) ? '0 : w_gnt_slot + PW'(1);

  always_comb begin
    ld_grant = '0;
    w_addr   = '0;
    w_dtag   = '0;
    st_grant = w_gnt_vld && (w_gnt_slot == PW'(NUM_LD));
    for (int i = 0; i < NUM_LD; i++) begin
      if (w_gnt_vld && (w_gnt_slot == PW'(i))) begin
        ld_grant[i] = 1'b1;
        w_addr      = ld_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_dtag      = 64'(w_gnt_slot);
      end
    end
    if (st_grant) begin
      w_addr = st_addr;
      w_dtag = st_data;
    end
  end

  always_comb begin
    w_pop_ok  = '0;
    w_pop_err = 1'b0;
    w_cnt_nz  = 1'b0;
    for (int i = 0; i < NUM_LD; i++) begin
      w_pop_ok[i] = ld_rsp_pop[i] && (r_cnt[i] != '0);
      if (ld_rsp_pop[i] && (r_cnt[i] == '0)) begin
        w_pop_err = 1'b1;
      end
      if (r_cnt[i] != '0) begin
        w_cnt_nz = 1'b1;
      end
    end
  end

  // A response with an in-range tag is still delivered if its client has no credit out,
  // but it is flagged since the memory returned something nobody asked for.
  always_comb begin
    w_rsp_vld    = rsp_mem_push && (rsp_mem_tag < 3'(NUM_LD));
    w_rsp_zero   = 1'b0;
    w_rsp_onehot = '0;
    for (int i = 0; i < NUM_LD; i++) begin
      if (w_rsp_vld && (rsp_mem_tag == 3'(i))) begin
        w_rsp_onehot[i] = 1'b1;
        if (r_cnt[i] == '0) begin
          w_rsp_zero = 1'b1;
        end
      end
    end
    w_rsp_err = (rsp_mem_push && !w_rsp_vld) || w_rsp_zero;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr    <= '0;
      r_mem_ld <= 1'b0;
      r_mem_st <= 1'b0;
      r_addr   <= '0;
      r_dtag   <= '0;
    end else begin
      if (w_gnt_vld) begin
        r_ptr <= w_ptr_nxt;
      end
      r_mem_ld <= |ld_grant;
      r_mem_st <= st_grant;
      r_addr   <= w_addr;
      r_dtag   <= w_dtag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_LD; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LD; i++) begin
        case ({ld_grant[i], w_pop_ok[i]})
          2'b10:   r_cnt[i] <= r_cnt[i] + CW'(1);
          2'b01:   r_cnt[i] <= r_cnt[i] - CW'(1);
          default: r_cnt[i] <= r_cnt[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_push <= '0;
      r_rsp_q    <= '0;
      r_tag_err  <= 1'b0;
    end else begin
      r_rsp_push <= w_rsp_onehot;
      if (w_rsp_vld) begin
        r_rsp_q <= rsp_mem_q;
      end
      if (w_pop_err || w_rsp_err) begin
        r_tag_err <= 1'b1;
      end
    end
  end

  assign req_mem_ld       = r_mem_ld;
  assign req_mem_st       = r_mem_st;
  assign req_mem_addr     = r_addr;
  assign req_mem_d_or_tag = r_dtag;
  assign ld_rsp_push      = r_rsp_push;
  assign ld_rsp_q         = r_rsp_q;
  assign tag_err          = r_tag_err;
  assign rsp_mem_stall    = 1'b0;

  assign busy = (|ld_req) | st_req | r_mem_ld | r_mem_st | (|r_rsp_push) | w_cnt_nz;

endmodule

// File: tb/tb_spmv_mem_arbiter.sv
// Directed bench for spmv_mem_arbiter: a round-robin/stall vector table plus
// hand-written sequences for credits, response routing, tag errors and reset.
module tb_spmv_mem_arbiter;
  localparam int NLD = 5;
  localparam int AW  = 48;

  logic             clk = 1'b0;
  logic             rst;
  logic [NLD-1:0]   ld_req;
  logic [NLD*AW-1:0] ld_addr;
  logic [NLD-1:0]   ld_grant;
  logic [NLD-1:0]   ld_rsp_push;
  logic [63:0]      ld_rsp_q;
  logic [NLD-1:0]   ld_rsp_pop;
  logic             st_req;
  logic [AW-1:0]    st_addr;
  logic [63:0]      st_data;
  logic             st_grant;
  logic             req_mem_ld;
  logic             req_mem_st;
  logic [AW-1:0]    req_mem_addr;
  logic [63:0]      req_mem_d_or_tag;
  logic             req_mem_stall;
  logic             rsp_mem_push;
  logic [2:0]       rsp_mem_tag;
  logic [63:0]      rsp_mem_q;
  logic             rsp_mem_stall;
  logic             busy;
  logic             tag_err;

  spmv_mem_arbiter #(.NUM_LD(NLD), .MAX_OUTSTANDING(16), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_grant(ld_grant),
    .ld_rsp_push(ld_rsp_push), .ld_rsp_q(ld_rsp_q), .ld_rsp_pop(ld_rsp_pop),
    .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_grant(st_grant),
    .req_mem_ld(req_mem_ld), .req_mem_st(req_mem_st), .req_mem_addr(req_mem_addr),
    .req_mem_d_or_tag(req_mem_d_or_tag), .req_mem_stall(req_mem_stall),
    .rsp_mem_push(rsp_mem_push), .rsp_mem_tag(rsp_mem_tag), .rsp_mem_q(rsp_mem_q),
    .rsp_mem_stall(rsp_mem_stall), .busy(busy), .tag_err(tag_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NLD-1:0] ldr;
    logic           st;
    logic           stall;
    int             slot;   // expected granted slot, -1 = none, NLD = store
  } vec_t;

  vec_t vt[23];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  function automatic logic [63:0] exp_addr(input int s);
    if (s < 0) return 64'h0;
    if (s == NLD) return 64'hF000;
    return 64'(32'h100 * (s + 1));
  endfunction

  function automatic logic [63:0] exp_tag(input int s);
    if (s < 0) return 64'h0;
    if (s == NLD) return 64'h5555_AAAA_1234_5678;
    return 64'(s);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rr_seq[10] = '{3, 4, 5, 0, 1, 2, 3, 4, 5, 0};
    int prev;
    int n_g;
    logic [NLD-1:0] exp_ld;

    rst = 1'b1; ld_req = '0; ld_addr = '0; ld_rsp_pop = '0;
    st_req = 1'b0; st_addr = 48'hF000; st_data = 64'h5555_AAAA_1234_5678;
    req_mem_stall = 1'b0; rsp_mem_push = 1'b0; rsp_mem_tag = '0; rsp_mem_q = '0;

    // Round-robin table: pointer is 3 on entry (after the single grant to client 2).
    for (int k = 0; k < 10; k++) vt[k] = '{ldr: 5'b11111, st: 1'b1, stall: 1'b0, slot: rr_seq[k]};
    for (int k = 10; k < 20; k++) vt[k] = '{ldr: 5'b11111, st: 1'b1, stall: 1'b1, slot: -1};
    vt[20] = '{ldr: 5'b11111, st: 1'b1, stall: 1'b0, slot: 1};
    vt[21] = '{ldr: 5'b11111, st: 1'b1, stall: 1'b0, slot: 2};
    vt[22] = '{ldr: 5'b00000, st: 1'b0, stall: 1'b0, slot: -1};

    repeat (3) tick();
    rst = 1'b0;
    tick(); settle();
    check("rst_ld_grant", ld_grant, 0);
    check("rst_st_grant", st_grant, 0);
    check("rst_req_ld", req_mem_ld, 0);
    check("rst_req_st", req_mem_st, 0);
    check("rst_addr", req_mem_addr, 0);
    check("rst_dtag", req_mem_d_or_tag, 0);
    check("rst_rsp_push", ld_rsp_push, 0);
    check("rst_rsp_q", ld_rsp_q, 0);
    check("rst_tag_err", tag_err, 0);
    check("rst_busy", busy, 0);
    check("rsp_mem_stall", rsp_mem_stall, 0);

    // Single load from client 2
    tick();
    ld_addr[2*AW +: AW] = 48'h1000;
    ld_req = 5'b00100;
    settle();
    check("t1_grant", ld_grant, 5'b00100);
    check("t1_no_issue_yet", req_mem_ld, 0);
    tick(); ld_req = '0; settle();
    check("t1_grant_drop", ld_grant, 0);
    check("t1_issue_ld", req_mem_ld, 1);
    check("t1_issue_st", req_mem_st, 0);
    check("t1_issue_addr", req_mem_addr, 64'h1000);
    check("t1_issue_tag", req_mem_d_or_tag, 2);
    check("t1_busy", busy, 1);
    tick(); settle();
    check("t1_issue_gone", req_mem_ld, 0);
    check("t1_addr_zero", req_mem_addr, 0);
    check("t1_tag_zero", req_mem_d_or_tag, 0);
    tick(); rsp_mem_push = 1'b1; rsp_mem_tag = 3'd2; rsp_mem_q = 64'hABCD; settle();
    check("t1_rsp_not_yet", ld_rsp_push, 0);
    tick(); rsp_mem_push = 1'b0; rsp_mem_q = 64'h0; settle();
    check("t1_rsp_push", ld_rsp_push, 5'b00100);
    check("t1_rsp_q", ld_rsp_q, 64'hABCD);
    tick(); settle();
    check("t1_rsp_push_off", ld_rsp_push, 0);
    check("t1_rsp_q_hold", ld_rsp_q, 64'hABCD);
    tick(); ld_rsp_pop = 5'b00100;
    tick(); ld_rsp_pop = '0; settle();
    check("t1_idle_busy", busy, 0);
    check("t1_tag_err", tag_err, 0);

    // Round-robin and stall table
    for (int i = 0; i < NLD; i++) ld_addr[i*AW +: AW] = AW'(32'h100 * (i + 1));
    prev = -1;
    for (int v = 0; v < 23; v++) begin
      tick();
      ld_req = vt[v].ldr; st_req = vt[v].st; req_mem_stall = vt[v].stall;
      settle();
      exp_ld = (vt[v].slot >= 0 && vt[v].slot < NLD) ? NLD'(1 << vt[v].slot) : '0;
      check($sformatf("rr%0d_ld_grant", v), ld_grant, exp_ld);
      check($sformatf("rr%0d_st_grant", v), st_grant, vt[v].slot == NLD);
      check($sformatf("rr%0d_req_ld", v), req_mem_ld, prev >= 0 && prev < NLD);
      check($sformatf("rr%0d_req_st", v), req_mem_st, prev == NLD);
      check($sformatf("rr%0d_addr", v), req_mem_addr, exp_addr(prev));
      check($sformatf("rr%0d_dtag", v), req_mem_d_or_tag, exp_tag(prev));
      prev = vt[v].slot;
    end
    // Each client holds two credits now
    tick(); ld_rsp_pop = 5'b11111;
    tick(); ld_rsp_pop = 5'b11111;
    tick(); ld_rsp_pop = '0; settle();
    check("rr_drain_busy", busy, 0);
    check("rr_tag_err", tag_err, 0);

    // Credit limit on client 0
    n_g = 0;
    for (int c = 0; c < 20; c++) begin
      tick(); ld_req = 5'b00001; settle();
      if (ld_grant[0]) n_g++;
      if (c == 19) check("cr_stopped", ld_grant, 0);
    end
    check("cr_grants", n_g, 16);
    tick(); ld_rsp_pop = 5'b00001; settle();
    n_g = int'(ld_grant[0]);
    for (int c = 0; c < 5; c++) begin
      tick(); ld_rsp_pop = '0; settle();
      if (ld_grant[0]) n_g++;
    end
    check("cr_extra_grant", n_g, 1);
    ld_req = '0;
    for (int c = 0; c < 16; c++) begin
      tick(); ld_rsp_pop = 5'b00001;
    end
    tick(); ld_rsp_pop = '0; settle();
    check("cr_busy", busy, 0);
    check("cr_tag_err", tag_err, 0);

    // Invalid tag
    tick(); rsp_mem_push = 1'b1; rsp_mem_tag = 3'd6; rsp_mem_q = 64'h1234;
    tick(); rsp_mem_push = 1'b0; settle();
    check("bad_tag_push", ld_rsp_push, 0);
    check("bad_tag_q_hold", ld_rsp_q, 64'hABCD);
    check("bad_tag_err", tag_err, 1);
    repeat (3) tick();
    settle();
    check("bad_tag_sticky", tag_err, 1);

    // Reset with loads in flight, then a late response
    n_g = 0;
    for (int c = 0; c < 4; c++) begin
      tick(); ld_req = 5'b00010; settle();
      if (ld_grant[1]) n_g++;
    end
    check("mr_grants", n_g, 4);
    tick(); ld_req = '0; settle();
    check("mr_issue", req_mem_ld, 1);
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; settle();
    check("mr_busy", busy, 0);
    check("mr_req_ld", req_mem_ld, 0);
    check("mr_addr", req_mem_addr, 0);
    check("mr_tag_err", tag_err, 0);
    check("mr_rsp_q", ld_rsp_q, 0);
    tick(); rsp_mem_push = 1'b1; rsp_mem_tag = 3'd1; rsp_mem_q = 64'h77;
    tick(); rsp_mem_push = 1'b0; settle();
    check("mr_late_tag_err", tag_err, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
